// File: rtl/systolic_feed_ctrl.sv
// Feed sequencer for one NxN systolic matmul pass: clear, K reads, drain, done.
// Optional cycle-count output enabled by SYSTOLIC_FEED_PERF_EN.
module systolic_feed_ctrl #(
  parameter int N      = 4,
  parameter int K_W    = 8,
  parameter int PE_LAT = 1
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_start,
  input  logic [K_W-1:0] i_k_len,
  output logic           o_busy,
  output logic           o_acc_clr,
  output logic           o_rd_en,
  output logic [K_W-1:0] o_rd_addr,
  output logic [N-1:0]   o_feed_en,
  output logic           o_done
`ifdef SYSTOLIC_FEED_PERF_EN
  ,
  output logic [15:0]    o_last_cycles
`endif
);

  localparam int TW = K_W + 1;
  localparam logic [TW-1:0] TAIL = TW'(2 * (N - 1) + PE_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  t_q, t_d;
  logic [K_W-1:0] k_q;
  logic [TW-1:0]  feed_last;
  logic [TW-1:0]  drain_last;
  logic           accept;
  logic           in_pass;

  assign accept     = (state_q == S_IDLE) && i_start;
  assign feed_last  = {1'b0, k_q} - TW'(1);
  assign drain_last = feed_last + TAIL;
  assign in_pass    = (state_q == S_FEED) || (state_q == S_DRAIN);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      if (accept && (i_k_len != '0)) begin
        k_q <= i_k_len;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    unique case (state_q)
      S_IDLE: begin
        t_d = '0;
        if (i_start) begin
          state_d = (i_k_len != '0) ? S_CLEAR : S_DONE;
        end
      end
      S_CLEAR: begin
        t_d     = '0;
        state_d = S_FEED;
      end
      S_FEED: begin
        t_d = t_q + TW'(1);
        if (t_q == feed_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        t_d = t_q + TW'(1);
        if (t_q == drain_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        t_d     = '0;
        state_d = S_IDLE;
      end
      default: begin
        t_d     = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_busy    = (state_q != S_IDLE);
  assign o_acc_clr = (state_q == S_CLEAR);
  assign o_rd_en   = (state_q == S_FEED);
  assign o_rd_addr = o_rd_en ? t_q[K_W-1:0] : '0;
  assign o_done    = (state_q == S_DONE);

  // lane r sees the operand stream delayed r cycles by the skew registers
  always_comb begin
    o_feed_en = '0;
    if (in_pass) begin
      for (int r = 0; r < N; r++) begin
        o_feed_en[r] = (t_q >= TW'(r)) &&
                       (t_q <= TW'(r) + feed_last);
      end
    end
  end

`ifdef SYSTOLIC_FEED_PERF_EN
  logic [15:0] cyc_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cyc_q         <= '0;
      o_last_cycles <= '0;
    end else begin
      if (accept) begin
        cyc_q <= 16'd1;
      end else if (o_busy && !o_done && (cyc_q != 16'hFFFF)) begin
        cyc_q <= cyc_q + 16'd1;
      end
      if (o_done) begin
        o_last_cycles <= cyc_q;
      end
    end
  end
`endif

endmodule
